// File: rtl/coe_upd_pkg.sv
// Shared constants, FSM encoding and the saturation helper for the LMS
// coefficient-update sequencer.
package coe_upd_pkg;

    localparam int NTAP = 32;
    localparam int AW   = 5;
    localparam int DW   = 16;

    localparam logic [AW-1:0] LAST_TAP = AW'(NTAP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        CLR   = 2'd3
    } state_e;

    // Clamp a DW+1-bit two's-complement sum into DW bits.
    function automatic logic [DW-1:0] sat_dw(input logic [DW:0] s);
        logic [DW-1:0] r;
        if (s[DW] != s[DW-1]) begin
            r = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            r = s[DW-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/coe_upd_alu.sv
// Per-lane coefficient update: coef + (grad >>> lamda).
// Define COE_UPD_SAT_EN to saturate the result; otherwise it wraps to DW bits.
module coe_upd_alu
    import coe_upd_pkg::*;
(
    input  logic [DW-1:0] coef,
    input  logic [DW-1:0] grad,
    input  logic [3:0]    lamda,
    output logic [DW-1:0] res
);

    logic signed [DW-1:0] delta_s;
    logic        [DW:0]   sum_s;

    // Sign-extend both operands so the add cannot lose the carry.
    always_comb begin
        delta_s = $signed(grad) >>> lamda;
        sum_s   = {coef[DW-1], coef} + {delta_s[DW-1], delta_s};
`ifdef COE_UPD_SAT_EN
        res     = sat_dw(sum_s);
`else
        res     = sum_s[DW-1:0];
`endif
    end

endmodule

// File: rtl/coe_update_ctrl.sv
// LMS coefficient-update sequencer: 3-stage fetch/read/write pipeline per tap
// plus a zeroing pass. Saturation is selected with COE_UPD_SAT_EN.
module coe_update_ctrl
    import coe_upd_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          clear,
    input  logic          freeze,
    input  logic [3:0]    lamda,
    output logic          grad_req,
    output logic [AW-1:0] grad_idx,
    input  logic          grad_vld,
    input  logic [DW-1:0] grad_i,
    input  logic [DW-1:0] grad_q,
    output logic          ram_re,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata_i,
    input  logic [DW-1:0] ram_rdata_q,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata_i,
    output logic [DW-1:0] ram_wdata_q,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    logic [AW-1:0] tap_q, tap_d;
    logic [3:0]    lamda_q, lamda_d;
    logic          s1_vld_q, s1_vld_d;
    logic [AW-1:0] s1_addr_q, s1_addr_d;
    logic [DW-1:0] g_i_q, g_i_d, g_q_q, g_q_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wd_i_q, wd_i_d, wd_q_q, wd_q_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          req_s, xfer_s;
    logic [DW-1:0] sum_i_s, sum_q_s;

    coe_upd_alu u_alu_i (.coef(ram_rdata_i), .grad(g_i_q), .lamda(lamda_q), .res(sum_i_s));
    coe_upd_alu u_alu_q (.coef(ram_rdata_q), .grad(g_q_q), .lamda(lamda_q), .res(sum_q_s));

    // Next-state, tap issue and pipeline advance.
    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        lamda_d   = lamda_q;
        s1_vld_d  = 1'b0;
        s1_addr_d = s1_addr_q;
        g_i_d     = g_i_q;
        g_q_d     = g_q_q;
        we_d      = s1_vld_q;
        waddr_d   = s1_addr_q;
        wd_i_d    = s1_vld_q ? sum_i_s : {DW{1'b0}};
        wd_q_d    = s1_vld_q ? sum_q_s : {DW{1'b0}};
        done_d    = 1'b0;
        req_s     = 1'b0;
        xfer_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = CLR;
                    tap_d   = {AW{1'b0}};
                end else if (start) begin
                    state_d = RUN;
                    tap_d   = {AW{1'b0}};
                    lamda_d = lamda;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                req_s  = ~freeze;
                xfer_s = req_s & grad_vld;
                if (xfer_s) begin
                    s1_vld_d  = 1'b1;
                    s1_addr_d = tap_q;
                    g_i_d     = grad_i;
                    g_q_d     = grad_q;
                    tap_d     = tap_q + AW'(1);
                    if (tap_q == LAST_TAP) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                // Last write is on the bus now; done lands the cycle after it.
                if (!s1_vld_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            CLR: begin
                if (we_q && (waddr_q == LAST_TAP)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (!freeze) begin
                    we_d    = 1'b1;
                    waddr_d = tap_q;
                    wd_i_d  = {DW{1'b0}};
                    wd_q_d  = {DW{1'b0}};
                    tap_d   = tap_q + AW'(1);
                end else begin
                    state_d = CLR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, pipeline and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tap_q     <= {AW{1'b0}};
            lamda_q   <= 4'd0;
            s1_vld_q  <= 1'b0;
            s1_addr_q <= {AW{1'b0}};
            g_i_q     <= {DW{1'b0}};
            g_q_q     <= {DW{1'b0}};
            we_q      <= 1'b0;
            waddr_q   <= {AW{1'b0}};
            wd_i_q    <= {DW{1'b0}};
            wd_q_q    <= {DW{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            lamda_q   <= lamda_d;
            s1_vld_q  <= s1_vld_d;
            s1_addr_q <= s1_addr_d;
            g_i_q     <= g_i_d;
            g_q_q     <= g_q_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wd_i_q    <= wd_i_d;
            wd_q_q    <= wd_q_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign grad_req    = req_s;
    assign grad_idx    = tap_q;
    assign ram_re      = xfer_s;
    assign ram_raddr   = tap_q;
    assign ram_we      = we_q;
    assign ram_waddr   = waddr_q;
    assign ram_wdata_i = wd_i_q;
    assign ram_wdata_q = wd_q_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
